// File: rtl/bus_master_if.sv
// Master-side bus interface: one CPU word access at a time, through
// request/grant arbitration, a single address strobe and a rdy_ wait with timeout.
module bus_master_if #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              cpu_busy,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  localparam int CNT_W =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TO_LAST_I =
    (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TO_LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit TO_EN = (TIMEOUT != 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             rdy;
  logic             timeout_hit;

  assign cpu_busy    = (state != IDLE);
  assign rdy         = ~bus_rdy_;
  assign timeout_hit = TO_EN && (cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      cpu_rd_data <= '0;
      cpu_done    <= 1'b0;
      cpu_err     <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            state       <= REQ;
            bus_req_    <= 1'b0;
            bus_addr    <= cpu_addr;
            bus_rw      <= cpu_rw;
            bus_wr_data <= cpu_wr_data;
          end
        end
        REQ: begin
          if (!bus_grnt_) begin
            state   <= ACCESS;
            bus_as_ <= 1'b0;
            cnt     <= '0;
          end
        end
        ACCESS: begin
          bus_as_ <= 1'b1;
          // rdy_ takes priority over a timeout on the same edge
          if (rdy || timeout_hit) begin
            if (rdy && bus_rw) cpu_rd_data <= bus_rd_data;
            cpu_done    <= rdy;
            cpu_err     <= ~rdy;
            state       <= IDLE;
            bus_req_    <= 1'b1;
            bus_addr    <= '0;
            bus_rw      <= 1'b1;
            bus_wr_data <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          bus_req_ <= 1'b1;
          bus_as_  <= 1'b1;
        end
      endcase
    end
  end

endmodule
